// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for two's-complement a-b.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_r;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;

  logic             w_h1;
  logic             w_g1;
  logic             w_s;
  logic             w_g2;
  logic             w_cn;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_sb_load;
  logic             w_c_load;

  // The single adder cell: two half adders plus an OR for the carry.
  always_comb begin
    w_h1 = r_sa[0] ^ r_sb[0];
    w_g1 = r_sa[0] & r_sb[0];
    w_s  = w_h1 ^ r_c;
    w_g2 = w_h1 & r_c;
    w_cn = w_g1 | w_g2;
    w_r_next = r_r >> 1;
    w_r_next[WIDTH-1] = w_s;
  end

`ifdef SERIAL_ADD_SUB_EN
  assign w_sb_load = sub ? ~b : b;
  assign w_c_load  = sub;
`else
  assign w_sb_load = b;
  assign w_c_load  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_r         <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= w_sb_load;
            r_c     <= w_c_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_r   <= w_r_next;
          r_c   <= w_cn;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum       <= w_r_next;
            r_carry_out <= w_cn;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  logic         start1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         sub1;
  logic         busy1;
  logic         done1;
  logic [0:0]   sum1;
  logic         co1;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_sum;
  logic         exp_co;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .a         (a1),
    .b         (b1),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub1),
`endif
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .carry_out (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation from the current (post-edge) point and follows it to done.
  // Leaves time just after the completion edge so a caller may start back-to-back.
  task automatic run_add(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input int poke);
    logic [W:0] full;
    int lat;
    full = {1'b0, ia} + (isub ? ({1'b0, ~ib} + 9'd1) : {1'b0, ib});
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_state busy=%b done=%b required busy=1 done=0", busy, done);
    end
    lat = 0;
    for (int i = 1; i <= W + 3; i++) begin
      if (i == poke) begin
        start = 1'b1; a = '1; b = '1; sub = 1'b0;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      n_checks++;
      if (sum !== exp_sum || carry_out !== exp_co || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_run cyc=%0d sum=%h co=%b busy=%b required sum=%h co=%b busy=1",
                 i, sum, carry_out, busy, exp_sum, exp_co);
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL latency got=%0d required=%0d", lat, W);
    end
    exp_sum = full[W-1:0];
    exp_co  = full[W];
    n_checks++;
    if (sum !== exp_sum || carry_out !== exp_co || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL result a=%h b=%h sub=%b sum=%h co=%b busy=%b required sum=%h co=%b busy=0",
               ia, ib, isub, sum, carry_out, busy, exp_sum, exp_co);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    #12;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values busy=%b done=%b sum=%h co=%b required 0 0 00 0",
               busy, done, sum, carry_out);
    end
    rst_n = 1'b1;
    exp_sum = '0; exp_co = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_add(8'h5A, 8'h3C, 1'b0, 0);
    n_checks++;
    if (sum !== 8'h96 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_5a_3c sum=%h co=%b required sum=96 co=0", sum, carry_out);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle done=%b required 0", done);
    end
  endtask

  task automatic test_back_to_back;
    run_add(8'hFF, 8'h01, 1'b0, 0);
    n_checks++;
    if (sum !== 8'h00 || carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first sum=%h co=%b required sum=00 co=1", sum, carry_out);
    end
    run_add(8'h00, 8'h00, 1'b0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start;
    int extra;
    run_add(8'h12, 8'h34, 1'b0, 3);
    n_checks++;
    if (sum !== 8'h46 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start sum=%h co=%b required sum=46 co=0", sum, carry_out);
    end
    extra = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL single_done extra_activity=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    a = 8'h80; b = 8'h80; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset busy=%b done=%b sum=%h co=%b required 0 0 00 0",
               busy, done, sum, carry_out);
    end
    exp_sum = '0; exp_co = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || sum !== '0) begin
      n_fail++;
      $display("FAIL abort_no_done activity=%0d sum=%h required 0 and 00", pulses, sum);
    end
    run_add(8'h01, 8'h02, 1'b0, 0);
    n_checks++;
    if (sum !== 8'h03) begin
      n_fail++;
      $display("FAIL post_reset_add sum=%h required 03", sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic s;
    for (int n = 0; n < 25; n++) begin
`ifdef SERIAL_ADD_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_add(W'($urandom), W'($urandom), s, (n % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0);
      if (n % 2 == 0) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    run_add(8'h10, 8'h01, 1'b1, 0);
    n_checks++;
    if (sum !== 8'h0F || carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_10_01 sum=%h co=%b required sum=0f co=1", sum, carry_out);
    end
    run_add(8'h01, 8'h02, 1'b1, 0);
    n_checks++;
    if (sum !== 8'hFF || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_01_02 sum=%h co=%b required sum=ff co=0", sum, carry_out);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_width1;
    logic [1:0] pat_a;
    logic [1:0] pat_b;
    logic [1:0] tot;
    pat_a = 2'b01; pat_b = 2'b11;
    for (int i = 0; i < 2; i++) begin
      a1 = pat_a[i]; b1 = pat_b[i]; sub1 = 1'b0; start1 = 1'b1;
      tot = {1'b0, pat_a[i]} + {1'b0, pat_b[i]};
      @(posedge clk); #1;
      start1 = 1'b0;
      n_checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL w1_accept busy=%b done=%b required busy=1 done=0", busy1, done1);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== tot[0] || co1 !== tot[1]) begin
        n_fail++;
        $display("FAIL w1_result done=%b busy=%b sum=%b co=%b required 1 0 %b %b",
                 done1, busy1, sum1, co1, tot[0], tot[1]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL w1_done_drop done=%b required 0", done1);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
